// File: rtl/keytone_player_pkg.sv
// Shared constants for keytone_player: note frequencies and FSM state encodings.
package keytone_player_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PLAY1 = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_PLAY2 = 2'd3;

  localparam int unsigned DIGIT_HZ [10] = '{262, 294, 330, 349, 392, 440, 494, 523, 587, 659};
  localparam int unsigned OP_HZ     = 784;
  localparam int unsigned CHIRP1_HZ = 880;
  localparam int unsigned CHIRP2_HZ = 1047;
  localparam int unsigned LOWEST_HZ = 262;

  function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned tone_hz);
    return clk_hz / (2 * tone_hz);
  endfunction

endpackage

// File: rtl/keytone_player_tone_divider.sv
// Square-wave generator: toggles every halfPeriod cycles while enabled,
// restarting from 0 on enable rising or a load strobe.
module tone_divider #(
  parameter int unsigned HalfW = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [HalfW-1:0] halfPeriod,
  input  logic             enable,
  input  logic             load,
  input  logic             hold,
  output logic             out
);

  logic [HalfW-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             out_q, out_d;
  logic             en_q;
  logic             restart;

  assign restart = load | (enable & ~en_q);

  // phase keeps the free-running square; out only follows it at a boundary
  // so a released hold resumes on the next half-period edge.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    out_d   = out_q;
    if (!enable || restart) begin
      cnt_d   = '0;
      phase_d = 1'b0;
      out_d   = 1'b0;
    end else if (cnt_q == halfPeriod - 1'b1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
      out_d   = ~phase_q & ~hold;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (hold) out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      out_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= out_d;
      en_q    <= enable;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/keytone_player.sv
// Key-feedback buzzer: one note per key, two-note chirp on submit.
// Optional KEYTONE_MUTE_EN adds a mute input that silences the pin only.
module keytone_player
  import keytone_player_pkg::*;
#(
  parameter int unsigned clkFreq = 1000000,
  parameter int unsigned beepMs  = 80,
  parameter int unsigned gapMs   = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       numPressed,
  input  logic       optPressed,
  input  logic       submit,
`ifdef KEYTONE_MUTE_EN
  input  logic       mute,
`endif
  output logic       buzzer,
  output logic       busy
);

  localparam int unsigned TICK  = clkFreq / 1000;
  localparam int unsigned PreW  = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned MaxMs = (beepMs > gapMs) ? beepMs : gapMs;
  localparam int unsigned MsW   = (MaxMs > 1) ? $clog2(MaxMs) : 1;
  localparam int unsigned HalfW = $clog2(clkFreq / (2 * LOWEST_HZ) + 1);

  localparam logic [PreW-1:0]  TICK_LAST   = PreW'(TICK - 1);
  localparam logic [MsW-1:0]   BEEP_LAST   = MsW'(beepMs - 1);
  localparam logic [MsW-1:0]   GAP_LAST    = MsW'(gapMs - 1);
  localparam logic [HalfW-1:0] OP_HALF     = HalfW'(half_period(clkFreq, OP_HZ));
  localparam logic [HalfW-1:0] CHIRP1_HALF = HalfW'(half_period(clkFreq, CHIRP1_HZ));
  localparam logic [HalfW-1:0] CHIRP2_HALF = HalfW'(half_period(clkFreq, CHIRP2_HZ));

  logic [1:0]       state_q, state_d;
  logic [MsW-1:0]   msCnt_q, msCnt_d;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [HalfW-1:0] half_q, half_d;
  logic             chirp_q, chirp_d;

  logic [HalfW-1:0] digitHalf [16];
  logic [HalfW-1:0] evHalf;
  logic             digitOk, accept, msTick, toneEn, toneHold, toneOut;

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) digitHalf[i] = '0;
    for (int unsigned i = 0; i < 10; i++) digitHalf[i] = HalfW'(half_period(clkFreq, DIGIT_HZ[i]));
  end

  assign digitOk = numPressed && (num <= 4'd9);
  assign accept  = submit | optPressed | digitOk;
  assign evHalf  = submit ? CHIRP1_HALF : (optPressed ? OP_HALF : digitHalf[num]);
  assign msTick  = (pre_q == TICK_LAST);

  always_comb begin
    state_d = state_q;
    msCnt_d = msCnt_q;
    half_d  = half_q;
    chirp_d = chirp_q;
    pre_d   = msTick ? '0 : pre_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        pre_d   = '0;
        msCnt_d = '0;
      end
      ST_PLAY1: if (msTick) begin
        if (msCnt_q == BEEP_LAST) begin
          msCnt_d = '0;
          state_d = chirp_q ? ST_GAP : ST_IDLE;
        end else begin
          msCnt_d = msCnt_q + 1'b1;
        end
      end
      ST_GAP: if (msTick) begin
        if (msCnt_q == GAP_LAST) begin
          msCnt_d = '0;
          half_d  = CHIRP2_HALF;
          state_d = ST_PLAY2;
        end else begin
          msCnt_d = msCnt_q + 1'b1;
        end
      end
      ST_PLAY2: if (msTick) begin
        if (msCnt_q == BEEP_LAST) begin
          msCnt_d = '0;
          state_d = ST_IDLE;
        end else begin
          msCnt_d = msCnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Any accepted event restarts the sequence from PLAY1, whatever the state.
    if (accept) begin
      state_d = ST_PLAY1;
      msCnt_d = '0;
      pre_d   = '0;
      half_d  = evHalf;
      chirp_d = submit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      msCnt_q <= '0;
      pre_q   <= '0;
      half_q  <= '0;
      chirp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      msCnt_q <= msCnt_d;
      pre_q   <= pre_d;
      half_q  <= half_d;
      chirp_q <= chirp_d;
    end
  end

  // Driven from next state so leaving a play state clears the pin on that edge.
  assign toneEn = (state_d == ST_PLAY1) || (state_d == ST_PLAY2);

`ifdef KEYTONE_MUTE_EN
  assign toneHold = mute;
  assign buzzer   = toneOut & ~mute;
`else
  assign toneHold = 1'b0;
  assign buzzer   = toneOut;
`endif

  tone_divider #(
    .HalfW(HalfW)
  ) u_tone (
    .clk       (clk),
    .reset     (reset),
    .halfPeriod(half_q),
    .enable    (toneEn),
    .load      (accept),
    .hold      (toneHold),
    .out       (toneOut)
  );

  assign busy = (state_q != ST_IDLE);

endmodule
